// File: rtl/main_bus_arbiter_pkg.sv
// main_bus_arbiter_pkg: shared bus transaction and arbiter state types for the MainBus arbiter
package main_bus_arbiter_pkg;
  typedef enum logic [1:0] {BUSNONE, BUSRD, BUSWR, BUSUPD} bus_txn_e;
  typedef enum logic [2:0] {IDLE, ARB, MEM_RD, MEM_WR, UPD, HOLD} arb_state_e;
  localparam int NUM_CACHES_DEF  = 4;
  localparam int MEM_TIMEOUT_DEF = 64;
endpackage

// File: rtl/main_bus_arbiter_rr_priority_picker.sv
// main_bus_arbiter_rr_priority_picker: first requester at or after ptr_i, wrapping, as one-hot and index
module main_bus_arbiter_rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  // Wrapped-around requesters are picked first, then overridden by any at or above the pointer.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k] && k < int'(ptr_i)) begin
        gnt_o   = N'(1) << k;
        idx_o   = W'(k);
        valid_o = 1'b1;
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k] && k >= int'(ptr_i)) begin
        gnt_o   = N'(1) << k;
        idx_o   = W'(k);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: round-robin MainBus arbiter/sequencer for Dragon caches (BusRd, write-back, BusUpd).
// Define ARB_WATCHDOG_EN to abort memory phases that exceed MEM_TIMEOUT cycles.
module main_bus_arbiter
  import main_bus_arbiter_pkg::*;
#(
  parameter int NUM_CACHES  = NUM_CACHES_DEF,
  parameter int OWNERBITS   = $clog2(NUM_CACHES),
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CACHES-1:0]      req_i,
  input  logic [NUM_CACHES-1:0][1:0] req_type_i,
  input  logic [NUM_CACHES-1:0]      release_bus_i,
  input  logic [NUM_CACHES-1:0]      shared_in_i,
  input  logic                       mem_ready_i,
  output logic [NUM_CACHES-1:0]      gnt_o,
  output logic [OWNERBITS-1:0]       owner_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  output logic                       snoop_busrd_o,
  output logic                       snoop_busupd_o,
  output logic                       snoop_shared_o,
  output logic                       busy_o,
  output logic                       timeout_err_o
);
  if (NUM_CACHES < 2 || NUM_CACHES > 8 || MEM_TIMEOUT < 1) begin : g_bad_param
    $error("main_bus_arbiter: NUM_CACHES must be 2..8 and MEM_TIMEOUT >= 1");
  end
  arb_state_e                state_q, state_d;
  logic [NUM_CACHES-1:0]     gnt_q, gnt_d, pick_gnt;
  logic [OWNERBITS-1:0]      owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic                      busy_q, busy_d, shared_q, shared_d, first_q;
  logic                      pick_valid, expire;
  bus_txn_e                  pick_txn;
  main_bus_arbiter_rr_priority_picker #(.N(NUM_CACHES), .W(OWNERBITS)) u_picker (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );
  assign pick_txn = bus_txn_e'(req_type_i[pick_idx]);
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    shared_d = shared_q;
    case (state_q)
      IDLE: state_d = |req_i ? ARB : IDLE;
      ARB: begin
        gnt_d   = pick_valid ? pick_gnt : gnt_q;
        owner_d = pick_valid ? pick_idx : owner_q;
        busy_d  = pick_valid;
        state_d = !pick_valid ? IDLE :
                  pick_txn == BUSRD ? MEM_RD :
                  pick_txn == BUSWR ? MEM_WR :
                  pick_txn == BUSUPD ? UPD : HOLD;
      end
      MEM_RD, MEM_WR: state_d = (mem_ready_i || expire) ? HOLD : state_q;
      UPD: state_d = HOLD;
      HOLD: if (release_bus_i[owner_q]) begin
        gnt_d    = '0;
        busy_d   = 1'b0;
        shared_d = 1'b0;
        ptr_d    = (owner_q == OWNERBITS'(NUM_CACHES - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Snoopers answer during the first cycle of the broadcast; the owner's own hit is meaningless.
    if ((state_q == MEM_RD || state_q == UPD) && first_q) shared_d = |(shared_in_i & ~gnt_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      shared_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      shared_q <= shared_d;
      first_q  <= state_q == ARB;
    end
  end
`ifdef ARB_WATCHDOG_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] wd_q;
  logic          to_q;
  logic          in_mem;
  assign in_mem = state_q == MEM_RD || state_q == MEM_WR;
  assign expire = in_mem && !mem_ready_i && wd_q == TW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= in_mem ? wd_q + 1'b1 : '0;
      to_q <= expire;
    end
  end
  assign timeout_err_o = to_q;
`else
  assign expire        = 1'b0;
  assign timeout_err_o = 1'b0;
`endif
  assign gnt_o          = gnt_q;
  assign owner_o        = owner_q;
  assign busy_o         = busy_q;
  assign snoop_shared_o = shared_q;
  assign mem_read_o     = state_q == MEM_RD;
  assign snoop_busrd_o  = state_q == MEM_RD;
  assign mem_write_o    = state_q == MEM_WR;
  assign snoop_busupd_o = state_q == UPD;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb_main_bus_arbiter: directed self-checking bench for main_bus_arbiter (default 4 caches)
module tb_main_bus_arbiter;
  import main_bus_arbiter_pkg::*;
  localparam int N = 4;
  logic             clk = 1'b0, rst_n = 1'b0, mrdy = 1'b0;
  logic [N-1:0]     req = '0, rel = '0, shin = '0;
  logic [N-1:0][1:0] rtype = '0;
  logic [N-1:0]     gnt;
  logic [1:0]       owner;
  logic             mem_read, mem_write, s_rd, s_upd, s_sh, busy, to_err;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  main_bus_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_type_i(rtype), .release_bus_i(rel),
    .shared_in_i(shin), .mem_ready_i(mrdy), .gnt_o(gnt), .owner_o(owner),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .snoop_busrd_o(s_rd),
    .snoop_busupd_o(s_upd), .snoop_shared_o(s_sh), .busy_o(busy), .timeout_err_o(to_err)
  );
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_outs", {gnt, owner, mem_read, mem_write, s_rd, s_upd, s_sh, busy, to_err}, 0);
    rst_n = 1'b1;
    // single BusRd requester, mem_ready on the third mem_read cycle
    req = 4'b0001; rtype[0] = BUSRD;
    tick();
    chk("t1_arb_gnt", gnt, 0);
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_rd", {mem_read, s_rd, busy, mem_write}, 4'b1110);
    req = '0;
    tick();
    chk("t1_rd2", mem_read, 1);
    tick();
    chk("t1_rd3", s_rd, 1);
    mrdy = 1'b1;
    tick();
    mrdy = 1'b0;
    chk("t1_hold", {mem_read, s_rd, busy}, 3'b001);
    chk("t1_hold_gnt", gnt, 4'b0001);
    rel = 4'b0001;
    tick();
    rel = '0;
    chk("t1_released", {busy, gnt}, 0);
    // reset while idle brings rr_ptr back to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    // all four request BUSWR: order 0,1,2,3,0
    req = 4'b1111;
    rtype = {BUSWR, BUSWR, BUSWR, BUSWR};
    tick(2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_gnt%0d", k), gnt, 4'b0001 << (k % 4));
      chk($sformatf("t2_owner%0d", k), owner, k % 4);
      chk($sformatf("t2_wr%0d", k), {mem_write, mem_read, s_rd, s_upd}, 4'b1000);
      mrdy = 1'b1;
      tick();
      mrdy = 1'b0;
      chk($sformatf("t2_onehot%0d", k), 32'($onehot(gnt)), 1);
      rel = gnt;
      tick();
      rel = '0;
      chk($sformatf("t2_idle%0d", k), busy, 0);
      if (k == 4) req = '0;
      tick(2);
    end
    // owner 2 BusUpd with own hit masked, then with a foreign hit
    req = 4'b0100; rtype[2] = BUSUPD; shin = 4'b0100;
    tick(2);
    chk("t3_upd", {s_upd, gnt}, 5'b10100);
    chk("t3_owner", owner, 2);
    req = '0;
    mrdy = 1'b1;
    tick();
    mrdy = 1'b0;
    chk("t3_upd_pulse", s_upd, 0);
    chk("t3_masked", s_sh, 0);
    rel = 4'b0001;
    tick();
    chk("t4_nonowner_rel", {busy, gnt}, 5'b10100);
    rel = 4'b0100;
    tick();
    rel = '0;
    chk("t4_owner_rel", {busy, gnt}, 0);
    req = 4'b0100; shin = 4'b0110;
    tick(2);
    chk("t3b_upd", {s_upd, gnt}, 5'b10100);
    req = '0;
    tick();
    chk("t3b_shared", {s_sh, s_upd}, 2'b10);
    rel = 4'b0100;
    tick();
    rel = '0; shin = '0;
    chk("t3b_cleared", {s_sh, busy}, 0);
    // asynchronous reset in the middle of a BusRd
    req = 4'b1000; rtype[3] = BUSRD;
    tick(2);
    chk("t5_rd", {mem_read, gnt}, 5'b11000);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async", {mem_read, s_rd, busy, gnt}, 0);
    #1 rst_n = 1'b1;
    req = 4'b1001; rtype[0] = BUSWR; rtype[3] = BUSWR;
    tick(2);
    chk("t5_lowest", gnt, 4'b0001);
    chk("t5_wr", mem_write, 1);
    req = '0;
    mrdy = 1'b1;
    tick();
    mrdy = 1'b0;
    rel = 4'b0001;
    tick();
    rel = '0;
    chk("t5_done", busy, 0);
    // memory never answers
    req = 4'b0010; rtype[1] = BUSRD;
    tick(2);
    chk("t6_rd", {mem_read, gnt}, 5'b10010);
    req = '0;
    tick(63);
    chk("t6_rd_last", {mem_read, to_err}, 2'b10);
    tick();
`ifdef ARB_WATCHDOG_EN
    chk("t6_timeout", {mem_read, to_err, busy}, 3'b011);
    tick();
    chk("t6_pulse_end", to_err, 0);
`else
    chk("t6_waiting", {mem_read, to_err, busy}, 3'b101);
    tick(40);
    chk("t6_still_waiting", {mem_read, to_err}, 2'b10);
    mrdy = 1'b1;
    tick();
    mrdy = 1'b0;
`endif
    chk("t6_hold", {mem_read, busy, gnt}, 6'b010010);
    rel = 4'b0010;
    tick();
    rel = '0;
    chk("t6_released", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
